// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scanner for a keypad lock: shifts entered
// digits into a 4-slot buffer and shows a blinking "Err " while the lock is in error.
module display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_SCANS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       clear,
    input  logic       err,
    output logic [3:0] code,
    output logic [3:0] an,
    output logic [2:0] entry_count
);

    localparam logic [15:0] RMAX  = 16'(REFRESH_DIV - 1);
    localparam logic [7:0]  BMAX  = 8'(BLINK_SCANS);
    localparam logic [3:0]  BLANK = 4'hE;

    typedef enum logic {ENTRY, ERROR} state_t;

    state_t          state_q, state_d;
    logic [3:0][3:0] slots;
    logic [2:0]      count_q;
    logic [15:0]     rcnt;
    logic [1:0]      idx;
    logic [7:0]      blink_cnt;
    logic            blink_on;

    logic            wrap, scan_done, enter_err, wipe, accept;
    logic [3:0]      glyph;

    assign wrap      = (rcnt == RMAX);
    assign scan_done = wrap && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ENTRY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTRY:   if (err)  state_d = ERROR;
            ERROR:   if (!err) state_d = ENTRY;
            default: state_d = ENTRY;
        endcase
    end

    always_comb begin
        enter_err = (state_q == ENTRY) && err;
        wipe      = clear || enter_err;
        accept    = (state_q == ENTRY) && digit_valid && (digit_in <= 4'd9) && (count_q < 3'd4);
        glyph     = BLANK;
        if (state_q == ENTRY) begin
            glyph = slots[idx];
        end else if (blink_on) begin
            case (idx)
                2'd3:    glyph = 4'hC;
                2'd2:    glyph = 4'hD;
                2'd1:    glyph = 4'hD;
                default: glyph = BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots     <= {4{BLANK}};
            count_q   <= 3'd0;
            rcnt      <= 16'd0;
            idx       <= 2'd0;
            blink_cnt <= 8'd0;
            blink_on  <= 1'b1;
            an        <= 4'b1110;
            code      <= BLANK;
        end else begin
            rcnt <= wrap ? 16'd0 : rcnt + 16'd1;
            if (wrap) idx <= idx + 2'd1;

            if (wipe) begin
                slots   <= {4{BLANK}};
                count_q <= 3'd0;
            end else if (accept) begin
                slots   <= {slots[2:0], digit_in};
                count_q <= count_q + 3'd1;
            end

            // Half-period is measured in whole scans, restarted on each error entry.
            if (enter_err) begin
                blink_cnt <= 8'd0;
                blink_on  <= 1'b1;
            end else if ((state_q == ERROR) && scan_done) begin
                if (blink_cnt + 8'd1 == BMAX) begin
                    blink_cnt <= 8'd0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end

            an   <= ~(4'b0001 << idx);
            code <= glyph;
        end
    end

    assign entry_count = count_q;

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit position stays selected; legal range 2..65535.
REQ-002 SHALL have parameter BLINK_SCANS, default 64: number of complete 4-digit scan cycles per error-blink half-period; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port digit_in, input, 4 bits: keypad digit value, sampled only when digit_valid=1.
REQ-006 SHALL have port digit_valid, input, 1 bit: single-cycle strobe meaning digit_in holds a new entered digit.
REQ-007 SHALL have port clear, input, 1 bit: single-cycle strobe that empties the entry buffer.
REQ-008 SHALL have port err, input, 1 bit: level input; high while the lock controller is in its error state.
REQ-009 SHALL have port code, output, 4 bits: registered glyph code for the seven-segment decoder (0-9 digits, 4'hC "E", 4'hD "r", 4'hE blank).
REQ-010 SHALL have port an, output, 4 bits: registered active-low anode select; exactly one bit is low at all times.
REQ-011 SHALL have port entry_count, output, 3 bits: number of digits held in the buffer, 0..4.

Function
REQ-012 SHALL hold four buffer slots, pos3 (leftmost) to pos0 (rightmost); an empty slot holds 4'hE.
REQ-013 SHALL, in ENTRY with digit_valid=1, digit_in<=9 and entry_count<4, shift pos2..pos0 into pos3..pos1, load digit_in into pos0, and increment entry_count, effective the next edge.
REQ-014 SHALL ignore digit_valid when digit_in>9, when entry_count=4 (buffer full; no shift, no wrap), or when the state is ERROR.
REQ-015 SHALL, on clear=1, set all slots to 4'hE and entry_count to 0 the next edge; clear takes priority over a simultaneous digit_valid.
REQ-016 SHALL implement two states: ENTRY and ERROR; ENTRY->ERROR when err=1, ERROR->ENTRY when err=0, each evaluated every edge.
REQ-017 SHALL, on the ENTRY->ERROR transition edge, empty the buffer (as REQ-015), reset the blink counter to 0 and set the blink phase to ON.
REQ-018 SHALL use a 16-bit refresh counter that counts 0..REFRESH_DIV-1 and wraps; on the wrap edge the scan index idx (2 bits) advances 0->1->2->3->0.
REQ-019 SHALL register an = ~(4'b0001 << idx) and code = glyph(idx) on every edge, so outputs follow idx and buffer with one cycle of latency.
REQ-020 SHALL, in ENTRY, set glyph(i) to the content of pos_i.
REQ-021 SHALL, in ERROR with blink phase ON, set glyph to pos3=4'hC, pos2=4'hD, pos1=4'hD, pos0=4'hE ("Err "); with phase OFF, set glyph to 4'hE for every position.
REQ-022 SHALL, in ERROR, count idx 3->0 transitions in an 8-bit blink counter; on reaching BLINK_SCANS it SHALL reset to 0 and toggle the blink phase.
REQ-023 SHALL leave the refresh counter and idx running continuously in both states, with no reset on state change.
REQ-024 SHALL drive entry_count from the registered count, so it updates the edge after the accepted digit or clear.

Reset
REQ-025 SHALL, while rst_n=0 and asynchronously, force: buffer all 4'hE, entry_count=0, state ENTRY, refresh counter=0, idx=0, blink counter=0, blink phase ON, an=4'b1110, code=4'hE.
REQ-026 SHALL resume scanning from idx=0, refresh count 0, on the first rising edge after rst_n deasserts; reset asserted mid-entry or mid-blink discards all state.

Verification (REFRESH_DIV=4, BLINK_SCANS=2)
REQ-027 Reset release, no stimulus -> an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; code stays 4'hE; entry_count=0.
REQ-028 digit_valid strobes with 1,2,3,4,5 -> entry_count 1,2,3,4,4; code shows 4 on an=1110, 3 on 1101, 2 on 1011, 1 on 0111; the digit 5 is dropped.
REQ-029 digit_valid with digit_in=4'hA, then digit_valid=1 with clear=1 in the same cycle -> entry_count stays 0; all positions show 4'hE.
REQ-030 Two digits entered, then err=1 -> buffer emptied; an=0111 shows C, 1011 shows D, 1101 shows D, 1110 shows E; after 2 full scans (32 cycles) all codes become 4'hE, and after 2 more the "Err " pattern returns.
REQ-031 err=1 with digit_valid strobes, then err=0 -> digits ignored; after return to ENTRY entry_count=0 and all positions 4'hE; the next digit 7 appears on an=1110.
REQ-032 rst_n pulsed low asynchronously mid-cycle during ERROR -> outputs take REQ-025 values immediately, before the next clock edge.
